// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit period and a
// helper that gives the total clock count of one frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // Clocks from the first start-bit clock to the last stop-bit clock inclusive
  function automatic int frame_clocks(input int clks_per_bit, input int data_bits,
                                      input int stop_bits, input int parity_bits);
    return (1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous restart holds the count at zero so the next bit period
// begins exactly on the clock after restart is released.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      restart,
  output logic [((CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1)-1:0] count,
  output logic                                                      tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  assign tick = (count == LAST);

  // Free-running bit-period counter, wraps on terminal count or restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {CW{1'b0}};
    end else if (restart || tick) begin
      count <= {CW{1'b0}};
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with internal baud timing and a ready/ack
// handshake that allows back-to-back frames with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit (sense set
// by PARITY_ODD) between the last data bit and the first stop bit.
// All outputs are registered; next-cycle values are computed from the next
// state so tx changes exactly on bit boundaries.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 ready,
  output logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // done is registered, so it is launched one clock before the final stop clock
  localparam logic [CW-1:0] DONE_CNT  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [3:0]           bit_idx_r, bit_idx_s;
  logic                 stop_idx_r, stop_idx_s;
  logic                 load_s, ack_s, busy_s, done_s, tx_s;
  logic [CW-1:0]        baud_count_s;
  logic                 baud_tick_s;
  logic                 baud_restart_s;

  // Counter sits at zero while idle, so START always gets a full bit period
  assign baud_restart_s = (state_r == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (baud_restart_s),
    .count   (baud_count_s),
    .tick    (baud_tick_s)
  );

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SENSE = 1'(PARITY_ODD);
  logic parity_r, parity_s;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_SENSE;
  endfunction

  // Parity is fixed at capture time so later data changes cannot alter it
  always_comb begin
    if (load_s) begin
      parity_s = frame_parity(data);
    end else begin
      parity_s = parity_r;
    end
  end

  // Parity bit register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_s;
    end
  end
`endif

  // Next-state, capture and next-output logic
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    load_s     = 1'b0;
    ack_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (ready) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_tick_s) begin
          state_s   = DATA;
          bit_idx_s = 4'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_idx_r == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
            stop_idx_s = 1'b0;
          end else begin
            bit_idx_s = bit_idx_r + 4'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (baud_tick_s) begin
          state_s    = STOP;
          stop_idx_s = 1'b0;
        end else begin
          state_s = PARITY;
        end
`else
        state_s = IDLE;
`endif
      end
      STOP: begin
        if (baud_tick_s) begin
          if (stop_idx_r == LAST_STOP) begin
            if (ready) begin
              load_s = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            stop_idx_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    // Capture path shared by IDLE and the final stop clock
    if (load_s) begin
      shift_s    = data;
      bit_idx_s  = 4'd0;
      stop_idx_s = 1'b0;
      ack_s      = 1'b1;
      state_s    = START;
    end else begin
      ack_s = 1'b0;
    end

    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = parity_s;
`else
      PARITY:  tx_s = 1'b1;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s = (state_s != IDLE);
    done_s = (state_r == STOP) && (stop_idx_r == LAST_STOP) && (baud_count_s == DONE_CNT);
  end

  // State, datapath and registered outputs; reset idles the line high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_BITS{1'b0}};
      bit_idx_r  <= 4'd0;
      stop_idx_r <= 1'b0;
      tx         <= 1'b1;
      ack        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      tx         <= tx_s;
      ack        <= ack_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8N1 and 5-bit/2-stop, both at
// 4 clocks per bit) checked every cycle against a frame-level model, plus
// literal expectations from hand-computed waveforms.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data0;
  logic [4:0] data1;
  logic       ready0, ready1;
  logic       ack0, busy0, done0, tx0;
  logic       ack1, busy1, done1, tx1;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .data(data0), .ready(ready0),
    .ack(ack0), .busy(busy0), .done(done0), .tx(tx0));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset(reset), .data(data1), .ready(ready1),
    .ack(ack1), .busy(busy1), .done(done1), .tx(tx1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int dbits_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction
  function automatic int sbits_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic int podd_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction
  function automatic int frame_len(input int db, input int sb);
    return (1 + db + PBITS + sb) * CPB;
  endfunction

  // Bit i of the result is the line level during bit period i of the frame
  function automatic logic [15:0] build_frame(input logic [8:0] d, input int db, input int podd);
    logic [15:0] f;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+db] = (^d) ^ (podd != 0);
`endif
    return f;
  endfunction

  logic [1:0]  ready_v;
  logic [8:0]  data_v [2];
  assign ready_v   = {ready1, ready0};
  assign data_v[0] = {1'b0, data0};
  assign data_v[1] = {4'b0000, data1};

  bit          m_active [2];
  int          m_k      [2];
  logic [15:0] m_bits   [2];
  bit          m_ack    [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_active[d] <= 1'b0;
        m_k[d]      <= 0;
        m_ack[d]    <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_active[d] || m_k[d] == frame_len(dbits_of(d), sbits_of(d)) - 1) begin
          if (ready_v[d]) begin
            m_active[d] <= 1'b1;
            m_k[d]      <= 0;
            m_bits[d]   <= build_frame(data_v[d], dbits_of(d), podd_of(d));
            m_ack[d]    <= 1'b1;
          end else begin
            m_active[d] <= 1'b0;
            m_k[d]      <= 0;
            m_ack[d]    <= 1'b0;
          end
        end else begin
          m_k[d]   <= m_k[d] + 1;
          m_ack[d] <= 1'b0;
        end
      end
    end
  end

  function automatic logic exp_tx(input bit act, input int k, input logic [15:0] bits);
    return act ? bits[k / CPB] : 1'b1;
  endfunction

  bit cmp_en = 1'b0;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx0",   tx0,   exp_tx(m_active[0], m_k[0], m_bits[0]));
      check("busy0", busy0, m_active[0]);
      check("ack0",  ack0,  m_ack[0]);
      check("done0", done0, m_active[0] && m_k[0] == frame_len(8, 1) - 1);
      check("tx1",   tx1,   exp_tx(m_active[1], m_k[1], m_bits[1]));
      check("busy1", busy1, m_active[1]);
      check("ack1",  ack1,  m_ack[1]);
      check("done1", done1, m_active[1] && m_k[1] == frame_len(5, 2) - 1);
    end
  end

  // ---------------- directed stimulus ----------------
  logic        txs0 [100];
  int          first_done0, first_done1, n_done0, n_done1, n_ack0, n_ack1;
  int          low1, high1, run, max_run, a_first, a_second;
  logic [10:0] exp_bits0;

  initial begin
    reset = 1'b0; ready0 = 1'b0; ready1 = 1'b0; data0 = 8'h00; data1 = 5'h00;
    repeat (3) @(negedge clk);
    check("reset_tx0", tx0, 1'b1);
    check("reset_busy0", busy0, 1'b0);
    check("reset_ack0", ack0, 1'b0);
    check("reset_done1", done1, 1'b0);
`ifdef UART_TX_PARITY_EN
    check("model_frame_a5", build_frame(9'h0A5, 8, 0), 16'hFD4A);
    check("model_len", frame_len(8, 1), 44);
    exp_bits0 = 11'b101_0100_1010;
`else
    check("model_frame_a5", build_frame(9'h0A5, 8, 0), 16'hFF4A);
    check("model_len", frame_len(8, 1), 40);
    exp_bits0 = 11'b111_0100_1010;
`endif
    cmp_en = 1'b1;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 on dut0 and 0x1F on dut1, single-cycle ready
    data0 = 8'hA5; ready0 = 1'b1; data1 = 5'h1F; ready1 = 1'b1;
    first_done0 = -1; first_done1 = -1; n_done0 = 0; n_done1 = 0;
    n_ack0 = 0; n_ack1 = 0; low1 = 0; high1 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin ready0 = 1'b0; ready1 = 1'b0; end
      txs0[c] = tx0;
      if (done0) begin n_done0++; if (first_done0 < 0) first_done0 = c; end
      if (done1) begin n_done1++; if (first_done1 < 0) first_done1 = c; end
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (c < frame_len(5, 2)) begin
        if (tx1) high1++; else low1++;
      end
    end
    for (int i = 0; i < 10 + PBITS; i++) check("a5_bit", txs0[CPB*i+2], exp_bits0[i]);
    check("a5_done_clock", first_done0, 39 + 4*PBITS);
    check("a5_done_count", n_done0, 1);
    check("a5_ack_count", n_ack0, 1);
    check("1f_low_clocks", low1, 4 + 4*PBITS);
    check("1f_high_clocks", high1, 28);
    check("1f_done_clock", first_done1, 31 + 4*PBITS);
    check("1f_ack_count", n_ack1, 1);

    // Back-to-back: ready held through two frames, data changed after ack
    data0 = 8'h00; ready0 = 1'b1;
    a_first = -1; a_second = -1; n_ack0 = 0; run = 0; max_run = 0;
    for (int c = 0; c < 98; c++) begin
      @(negedge clk);
      if (c == 0) data0 = 8'hFF;
      if (ack0) begin
        n_ack0++;
        if (a_first < 0) a_first = c; else if (a_second < 0) a_second = c;
        if (c > 0) ready0 = 1'b0;
      end
      if (c < frame_len(8, 1) + CPB) begin
        if (tx0) run++; else run = 0;
        if (run > max_run) max_run = run;
      end
    end
    check("b2b_ack_count", n_ack0, 2);
    check("b2b_first_ack", a_first, 0);
    check("b2b_spacing", a_second - a_first, 40 + 4*PBITS);
    check("b2b_max_high_run", max_run, CPB);

    // Asynchronous reset in the middle of a frame
    data0 = 8'h00; ready0 = 1'b1; data1 = 5'h00; ready1 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) begin ready0 = 1'b0; ready1 = 1'b0; end
    end
    check("pre_reset_tx0", tx0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx0", tx0, 1'b1);
    check("async_reset_busy0", busy0, 1'b0);
    check("async_reset_tx1", tx1, 1'b1);
    check("async_reset_busy1", busy1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_done0 = 0; n_done1 = 0; low1 = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done0) n_done0++;
      if (done1) n_done1++;
      if (!tx0 || !tx1) low1++;
    end
    check("post_reset_done", n_done0 + n_done1, 0);
    check("post_reset_tx_low", low1, 0);

    // ready pulsed mid-frame must be ignored
    data0 = 8'h3C; ready0 = 1'b1;
    n_ack0 = 0; first_done0 = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0) ready0 = 1'b0;
      if (c == 12) begin data0 = 8'hFF; ready0 = 1'b1; end
      if (c == 13) begin data0 = 8'h00; ready0 = 1'b0; end
      if (ack0) n_ack0++;
      if (done0 && first_done0 < 0) first_done0 = c;
    end
    check("midready_ack_count", n_ack0, 1);
    check("midready_done_clock", first_done0, 39 + 4*PBITS);
    check("midready_idle_busy", busy0, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter; successor to the fixed 8-bit, one-bit-per-clock serialiser. Adds an internal baud divider, configurable data width and stop-bit count, optional parity, and a ready/ack/busy handshake that allows back-to-back frames with no idle gap. Sits between the Nios-side data register and the serial output pin.

## Interface
- CLKS_PER_BIT, 434, system clocks per bit period (≥2; 434 = 50 MHz / 115200)
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- PARITY_ODD, 0, parity sense when parity compiled in: 0 even, 1 odd
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; one clock, no other reset
- data  input  DATA_BITS  payload, LSB transmitted first
- ready  input  1  request to send `data`; level, sampled each clock
- ack  output  1  one-cycle pulse: `data` captured this cycle
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse on the last clock of the final stop bit
- tx  output  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset (reset low) forces IDLE immediately, regardless of clk.
- Reset values: tx=1, busy=0, ack=0, done=0; baud counter, bit index, stop counter = 0.
- IDLE: tx=1. If ready=1: latch data into shift register, ack=1, go START.
- START: tx=0 for CLKS_PER_BIT clocks, then DATA with bit index 0.
- DATA: tx=shift[0]; every CLKS_PER_BIT clocks shift right, index+1. After index DATA_BITS-1 → PARITY (if compiled in) else STOP.
- PARITY: tx = XOR of latched data XOR PARITY_ODD for one bit period → STOP.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT clocks. On the final clock done=1; if ready=1 that same clock, latch data, ack=1, go START (no idle gap); else go IDLE.
- ready while busy outside the final stop clock: ignored, no ack; data not sampled.
- data changes after ack do not affect the frame in flight.
- Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); restarts at 0 on every state entry.
- busy = (state != IDLE).

## Timing
- ready sampled high in IDLE at edge N → ack high N..N+1, tx falls and busy rises after edge N.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT clocks, P=1 with parity else 0; tx edge-aligned to bit boundaries, no jitter.
- done asserts on clock F-1 of the frame (counting from the first START clock as 0).
- Back-to-back: next START begins the clock after done; consecutive frames exactly F clocks apart.
- Reset asserted mid-frame: tx=1 asynchronously; after release, block is in IDLE and needs a new ready; interrupted frame is not resumed.
- Outputs registered; no combinational path ready→tx.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, parity bit inserted between last data bit and first stop bit, sense from PARITY_ODD.
- Undefined: PARITY state and parity logic absent; PARITY_ODD ignored; DATA → STOP directly.

## Structure
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), default CLKS_PER_BIT constant, frame-length helper function.
- One sub-module: uart_baud_tick (counter 0..CLKS_PER_BIT-1, synchronous restart input, tick output on terminal count); reused by the future receiver.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, no parity, data=0xA5 one-cycle ready → tx per 4-clock bit: 0,1,0,1,0,0,1,0,1,1; done on clock 39; ack exactly once.
- UART_TX_PARITY_EN, data=0xA5: PARITY_ODD=0 → parity bit 0; PARITY_ODD=1 → parity bit 1; frame 44 clocks.
- ready held high with 0x00 then 0xFF → two frames exactly 40 clocks apart, tx never high between first frame's stop bit and second start bit beyond one bit period; two ack pulses.
- STOP_BITS=2, DATA_BITS=5, data=0x1F → tx low 4 clocks, high 28 clocks; done on clock 31.
- reset low at clock 17 of a frame → tx=1 and busy=0 without waiting for clk; after release with ready=0, tx stays 1, no done.
- ready pulsed while busy (mid DATA) → no ack, frame unchanged, block returns to IDLE after done.
